frame_strobe_gen: RTL and testbench
===================================

# frame_strobe_gen

Configuration-side frame writer for the 60x34 fabric. Accepts frame-write commands (column, frame index, frame data) over a valid/ready handshake. Drives the shared `FrameData` row bus and a one-hot `FrameStrobe` pulse into the selected column. The strobe enters the column at its bottom and is buffered tile by tile up to the north termination tile. Sequencing guarantees data setup before, and hold after, every strobe pulse.

## Interface
- `MaxFramesPerCol`, 20, frames per column (strobe lines per column)
- `FrameBitsPerRow`, 32, width of frame data word
- `NumColumns`, 60, fabric columns addressed
- `ColSelWidth`, 6, width of column select; must satisfy 2^ColSelWidth >= NumColumns
- `FrameSelWidth`, 5, width of frame select; must satisfy 2^FrameSelWidth >= MaxFramesPerCol
- `SetupCycles`, 1, cycles `FrameData` is stable before strobe rises; must be >= 1
- `StrobeCycles`, 2, strobe high time in cycles; must be >= 1

Ports:
- `UserCLK` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block idle and able to accept.
- `cmd_col` in ColSelWidth: target column.
- `cmd_frame` in FrameSelWidth: target frame within column.
- `cmd_data` in FrameBitsPerRow: frame data word.
- `err_clr` in 1: clears `err`.
- `FrameData` out FrameBitsPerRow: registered data to the fabric row.
- `FrameStrobe` out NumColumns*MaxFramesPerCol: registered strobes. Bit index is col*MaxFramesPerCol+frame.
- `busy` out 1: not IDLE.
- `err` out 1: sticky flag for an illegal address.
- `frame_count` out 16: count of completed strobes.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE: `cmd_ready`=1. Acceptance is `cmd_valid && cmd_ready` at a rising edge.
- Accept with legal address (cmd_col < NumColumns and cmd_frame < MaxFramesPerCol):
  - Latch `cmd_data` into `FrameData`.
  - Latch the decoded strobe index.
  - Go to SETUP and load the counter with SetupCycles-1.
- Accept with illegal address:
  - Set `err`.
  - `FrameData` and `FrameStrobe` are unchanged and no strobe is issued.
  - Stay in IDLE; `cmd_ready` stays 1.
- SETUP: all strobes 0, data held. When the counter reaches 0, go to STROBE and load StrobeCycles-1.
- STROBE: exactly one `FrameStrobe` bit is 1, data held. When the counter reaches 0, go to HOLD.
- HOLD: one cycle, strobes 0, data held. Increment `frame_count` (wraps 0xFFFF -> 0x0000). Then go to IDLE.
- `FrameData` retains its last value in IDLE and is not cleared.
- `err`:
  - Cleared by `err_clr`.
  - If an illegal accept and `err_clr` occur in the same cycle, set wins.
- `cmd_*` inputs are ignored outside IDLE; `cmd_ready`=0 there.
- `busy` = (state != IDLE).

## Timing
- All outputs are registered, except `cmd_ready` and `busy`, which are decoded from the state register.
- Acceptance edge e0:
  - `FrameData` is valid from e0.
  - Strobe rises at edge e0+SetupCycles and falls at e0+SetupCycles+StrobeCycles.
  - IDLE resumes at e0+SetupCycles+StrobeCycles+1.
- `frame_count` updates at the HOLD->IDLE edge.
- Defaults: `cmd_ready` is low for 4 cycles, so back-to-back throughput is 1 frame per 5 cycles.
- Reset values:
  - state IDLE, `cmd_ready`=1, `busy`=0.
  - `FrameData`=0, `FrameStrobe`=0, `err`=0, `frame_count`=0.
- Reset asserted mid-operation: strobes and data clear asynchronously, with no glitch beyond the reset edge. After deassertion the block sits in IDLE, the interrupted frame is dropped, and it is not counted.

## Structure
- Package `frame_strobe_pkg` holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD);
  - the counter width localparam, clog2(max(SetupCycles, StrobeCycles));
  - the `frame_count` width constant (16).
- Sub-module `strobe_onehot_dec`:
  - Parameterised by NumColumns and MaxFramesPerCol.
  - Combinational (col, frame, en) -> one-hot vector; en is high only in STROBE.
  - Its output feeds the `FrameStrobe` register.
- The top holds the FSM, counter, data register, error flag and frame counter.

## Test plan
- Reset, then cmd col=0 frame=0 data=0xDEADBEEF:
  - `FrameData`=0xDEADBEEF from e0.
  - `FrameStrobe[0]` is high on cycles e0+1..e0+2.
  - `frame_count`=1 and `cmd_ready`=1 at e0+4.
- cmd col=59 frame=19: only bit 1199 pulses for 2 cycles; all other 1199 bits stay 0 throughout.
- cmd col=60 frame=3, then col=2 frame=20:
  - `err`=1 and no strobe issued.
  - `cmd_ready` never drops.
  - `err_clr` pulse clears `err`; `err_clr` together with a new illegal cmd leaves `err`=1.
- `cmd_valid` held high with 3 legal commands: accepts spaced exactly 5 cycles apart; changing inputs while busy has no effect on `FrameData`.
- `resetn` pulsed low during STROBE: strobe and data go to 0 immediately; `frame_count` unchanged; the next command runs normally.
- Preload 0xFFFF completed frames (or force `frame_count`), then one more frame: `frame_count` wraps to 0x0000.

Source files
------------

// File: rtl/frame_strobe_pkg.sv
// Shared FSM state type and sizing helpers for the configuration frame writer.
package frame_strobe_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam int FrameCountWidth = 16;
   localparam int SetupCyclesDef  = 1;
   localparam int StrobeCyclesDef = 2;

   // The counter holds values 0..max-1, so clog2(max) bits suffice; never narrower than 1 bit.
   function automatic int cnt_width(input int setup_cycles, input int strobe_cycles);
      int m;
      m = (setup_cycles > strobe_cycles) ? setup_cycles : strobe_cycles;
      return (m > 2) ? $clog2(m) : 1;
   endfunction

   localparam int CntWidth = cnt_width(SetupCyclesDef, StrobeCyclesDef);

endpackage

// File: rtl/strobe_onehot_dec.sv
// Combinational (column, frame) to one-hot strobe vector; all zeros while en is low.
module strobe_onehot_dec #(
   parameter int NumColumns      = 60,
   parameter int MaxFramesPerCol = 20,
   parameter int ColSelWidth     = 6,
   parameter int FrameSelWidth   = 5
) (
   input  logic                                  en,
   input  logic [ColSelWidth-1:0]                col,
   input  logic [FrameSelWidth-1:0]              frame,
   output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

   int sel;

   always_comb begin
      sel    = int'(col) * MaxFramesPerCol + int'(frame);
      strobe = '0;
      for (int i = 0; i < NumColumns*MaxFramesPerCol; i++) begin
         strobe[i] = en && (i == sel);
      end
   end

endmodule

// File: rtl/frame_strobe_gen.sv
// Frame writer: latches one command, then drives FrameData with a setup/strobe/hold
// sequence on a single FrameStrobe line of the addressed column.
module frame_strobe_gen
   import frame_strobe_pkg::*;
#(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int NumColumns      = 60,
   parameter int ColSelWidth     = 6,
   parameter int FrameSelWidth   = 5,
   parameter int SetupCycles     = SetupCyclesDef,
   parameter int StrobeCycles    = StrobeCyclesDef
) (
   input  logic                                  UserCLK,
   input  logic                                  resetn,
   input  logic                                  cmd_valid,
   output logic                                  cmd_ready,
   input  logic [ColSelWidth-1:0]                cmd_col,
   input  logic [FrameSelWidth-1:0]              cmd_frame,
   input  logic [FrameBitsPerRow-1:0]            cmd_data,
   input  logic                                  err_clr,
   output logic [FrameBitsPerRow-1:0]            FrameData,
   output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
   output logic                                  busy,
   output logic                                  err,
   output logic [FrameCountWidth-1:0]            frame_count
);

   localparam int NumStrobes = NumColumns * MaxFramesPerCol;
   localparam int CntNeed    = cnt_width(SetupCycles, StrobeCycles);
   localparam int CntW       = (CntNeed > CntWidth) ? CntNeed : CntWidth;

   localparam logic [CntW-1:0]            SetupLoad  = CntW'(SetupCycles - 1);
   localparam logic [CntW-1:0]            StrobeLoad = CntW'(StrobeCycles - 1);
   localparam logic [CntW-1:0]            CntOne     = CntW'(1);
   localparam logic [FrameCountWidth-1:0] CountOne   = FrameCountWidth'(1);

   state_t                    state, state_d;
   logic [CntW-1:0]           cnt, cnt_d;
   logic [ColSelWidth-1:0]    col_p0;
   logic [FrameSelWidth-1:0]  frame_p0;
   logic [NumStrobes-1:0]     strobe_nxt;
   logic                      accept, legal;

   assign legal     = (int'(cmd_col) < NumColumns) && (int'(cmd_frame) < MaxFramesPerCol);
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         IDLE: begin
            if (accept && legal) begin
               state_d = SETUP;
               cnt_d   = SetupLoad;
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               state_d = STROBE;
               cnt_d   = StrobeLoad;
            end else begin
               cnt_d = cnt - CntOne;
            end
         end
         STROBE: begin
            if (cnt == '0) state_d = HOLD;
            else           cnt_d   = cnt - CntOne;
         end
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Decoding the next state keeps FrameStrobe itself a clean register output.
   strobe_onehot_dec #(
      .NumColumns      (NumColumns),
      .MaxFramesPerCol (MaxFramesPerCol),
      .ColSelWidth     (ColSelWidth),
      .FrameSelWidth   (FrameSelWidth)
   ) u_dec (
      .en     (state_d == STROBE),
      .col    (col_p0),
      .frame  (frame_p0),
      .strobe (strobe_nxt)
   );

   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         col_p0      <= '0;
         frame_p0    <= '0;
         FrameData   <= '0;
         FrameStrobe <= '0;
         err         <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         FrameStrobe <= strobe_nxt;
         if (accept && legal) begin
            FrameData <= cmd_data;
            col_p0    <= cmd_col;
            frame_p0  <= cmd_frame;
         end
         // An illegal accept outranks a simultaneous clear.
         if (accept && !legal) err <= 1'b1;
         else if (err_clr)     err <= 1'b0;
         if (state == HOLD) frame_count <= frame_count + CountOne;
      end
   end

endmodule

// File: tb/tb_frame_strobe_gen.sv
// Randomized and directed bench for frame_strobe_gen against a timestamp-based reference model.
module tb_frame_strobe_gen;

   localparam int NC  = 60;
   localparam int MF  = 20;
   localparam int FB  = 32;
   localparam int CW  = 6;
   localparam int FW  = 5;
   localparam int SC  = 1;
   localparam int STC = 2;
   localparam int NS  = NC * MF;

   logic          UserCLK = 1'b0;
   logic          resetn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          err_clr = 1'b0;
   logic [CW-1:0] cmd_col = '0;
   logic [FW-1:0] cmd_frame = '0;
   logic [FB-1:0] cmd_data = '0;
   logic          cmd_ready, busy, err;
   logic [FB-1:0] FrameData;
   logic [NS-1:0] FrameStrobe;
   logic [15:0]   frame_count;

   int passed = 0;
   int total  = 0;

   // Reference model: each legal accept at edge e0 owns the window [e0, e0+SC+STC+1).
   int            cyc = 0;
   int            busy_until = 0;
   int            m_e0 = 0;
   int            m_idx = 0;
   bit            pending = 0;
   logic [FB-1:0] m_data = '0;
   logic          m_err = 1'b0;
   logic [15:0]   m_count = '0;

   always #5 UserCLK = ~UserCLK;

   frame_strobe_gen #(
      .MaxFramesPerCol (MF),
      .FrameBitsPerRow (FB),
      .NumColumns      (NC),
      .ColSelWidth     (CW),
      .FrameSelWidth   (FW),
      .SetupCycles     (SC),
      .StrobeCycles    (STC)
   ) dut (
      .UserCLK     (UserCLK),
      .resetn      (resetn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_col     (cmd_col),
      .cmd_frame   (cmd_frame),
      .cmd_data    (cmd_data),
      .err_clr     (err_clr),
      .FrameData   (FrameData),
      .FrameStrobe (FrameStrobe),
      .busy        (busy),
      .err         (err),
      .frame_count (frame_count)
   );

   task automatic tick();
      bit rdy, legal;
      @(posedge UserCLK);
      rdy   = (cyc >= busy_until);
      cyc++;
      legal = (int'(cmd_col) < NC) && (int'(cmd_frame) < MF);
      if (resetn) begin
         if (pending && cyc == busy_until) begin
            m_count = m_count + 16'd1;
            pending = 0;
         end
         if (rdy && cmd_valid && legal) begin
            m_data     = cmd_data;
            m_idx      = int'(cmd_col) * MF + int'(cmd_frame);
            m_e0       = cyc;
            busy_until = cyc + SC + STC + 1;
            pending    = 1;
         end
         if (rdy && cmd_valid && !legal) m_err = 1'b1;
         else if (err_clr)               m_err = 1'b0;
      end
      #1;
   endtask

   task automatic model_reset();
      busy_until = cyc;
      pending    = 0;
      m_data     = '0;
      m_err      = 1'b0;
      m_count    = '0;
   endtask

   function automatic logic [NS-1:0] exp_strobe();
      logic [NS-1:0] v;
      v = '0;
      if (pending && cyc >= m_e0 + SC && cyc < m_e0 + SC + STC) v[m_idx] = 1'b1;
      return v;
   endfunction

   task automatic test_reset();
      resetn = 1'b0;
      #3;
      total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got=%b want=1", cmd_ready); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
      total++; if (FrameData !== '0) $display("FAIL reset_data got=%h want=0", FrameData); else passed++;
      total++; if (FrameStrobe !== '0) $display("FAIL reset_strobe ones=%0d want=0", $countones(FrameStrobe)); else passed++;
      total++; if (err !== 1'b0) $display("FAIL reset_err got=%b want=0", err); else passed++;
      total++; if (frame_count !== 16'h0) $display("FAIL reset_count got=%h want=0", frame_count); else passed++;
      tick();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      cmd_col = 6'd7; cmd_frame = 5'd4; cmd_data = 32'hA5A5_0F0F; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      total++; if (FrameStrobe[7*MF+4] !== 1'b1) $display("FAIL mid_pre_strobe got=%b want=1", FrameStrobe[7*MF+4]); else passed++;
      #2 resetn = 1'b0;
      #1;
      total++; if (FrameStrobe !== '0) $display("FAIL mid_strobe_clear ones=%0d want=0", $countones(FrameStrobe)); else passed++;
      total++; if (FrameData !== '0) $display("FAIL mid_data_clear got=%h want=0", FrameData); else passed++;
      total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL mid_idle ready=%b busy=%b want=1/0", cmd_ready, busy); else passed++;
      model_reset();
      @(negedge UserCLK);
      resetn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if (FrameStrobe !== '0) $display("FAIL mid_no_resume k=%0d ones=%0d want=0", k, $countones(FrameStrobe)); else passed++;
      end
      total++; if (frame_count !== 16'h0) $display("FAIL mid_not_counted got=%h want=0", frame_count); else passed++;
      cmd_col = 6'd3; cmd_frame = 5'd5; cmd_data = 32'h1234_5678; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         total++;
         if (FrameStrobe[3*MF+5] !== ((k == 1 || k == 2) ? 1'b1 : 1'b0))
            $display("FAIL mid_next_strobe k=%0d got=%b", k, FrameStrobe[3*MF+5]);
         else passed++;
      end
      total++; if (frame_count !== 16'h1) $display("FAIL mid_next_count got=%h want=1", frame_count); else passed++;
   endtask

   task automatic test_single();
      logic [15:0] want;
      want = m_count + 16'd1;
      cmd_col = 6'd0; cmd_frame = 5'd0; cmd_data = 32'hDEAD_BEEF; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      total++; if (FrameData !== 32'hDEAD_BEEF) $display("FAIL single_data got=%h want=deadbeef", FrameData); else passed++;
      total++; if (FrameStrobe !== '0 || cmd_ready !== 1'b0) $display("FAIL single_setup ones=%0d ready=%b want=0/0", $countones(FrameStrobe), cmd_ready); else passed++;
      for (int k = 1; k <= 2; k++) begin
         tick();
         total++;
         if (FrameStrobe[0] !== 1'b1 || $countones(FrameStrobe) != 1)
            $display("FAIL single_strobe k=%0d bit0=%b ones=%0d want=1/1", k, FrameStrobe[0], $countones(FrameStrobe));
         else passed++;
      end
      tick();
      total++; if (FrameStrobe !== '0 || cmd_ready !== 1'b0) $display("FAIL single_hold ones=%0d ready=%b want=0/0", $countones(FrameStrobe), cmd_ready); else passed++;
      tick();
      total++; if (cmd_ready !== 1'b1) $display("FAIL single_ready got=%b want=1", cmd_ready); else passed++;
      total++; if (frame_count !== want) $display("FAIL single_count got=%h want=%h", frame_count, want); else passed++;
      total++; if (FrameData !== 32'hDEAD_BEEF) $display("FAIL single_data_kept got=%h want=deadbeef", FrameData); else passed++;
   endtask

   task automatic test_corner();
      logic [NS-1:0] one_hot;
      int            highs;
      one_hot = '0;
      one_hot[NS-1] = 1'b1;
      highs = 0;
      cmd_col = 6'd59; cmd_frame = 5'd19; cmd_data = $urandom(); cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) tick();
         if (FrameStrobe[NS-1] === 1'b1) highs++;
         total++;
         if (FrameStrobe !== ((k == 1 || k == 2) ? one_hot : '0))
            $display("FAIL corner_vec k=%0d ones=%0d top=%b", k, $countones(FrameStrobe), FrameStrobe[NS-1]);
         else passed++;
      end
      total++; if (highs != 2) $display("FAIL corner_width got=%0d want=2", highs); else passed++;
   endtask

   task automatic test_illegal();
      logic [FB-1:0] held;
      held = m_data;
      cmd_col = 6'd60; cmd_frame = 5'd3; cmd_data = 32'hBAD0_0001; cmd_valid = 1'b1;
      tick();
      total++; if (err !== 1'b1) $display("FAIL illegal_col_err got=%b want=1", err); else passed++;
      total++; if (cmd_ready !== 1'b1) $display("FAIL illegal_col_ready got=%b want=1", cmd_ready); else passed++;
      cmd_col = 6'd2; cmd_frame = 5'd20; cmd_data = 32'hBAD0_0002;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         total++;
         if (FrameStrobe !== '0 || cmd_ready !== 1'b1 || FrameData !== held)
            $display("FAIL illegal_quiet k=%0d ones=%0d ready=%b data=%h want=0/1/%h", k, $countones(FrameStrobe), cmd_ready, FrameData, held);
         else passed++;
      end
      total++; if (err !== 1'b1) $display("FAIL illegal_sticky got=%b want=1", err); else passed++;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      total++; if (err !== 1'b0) $display("FAIL illegal_clr got=%b want=0", err); else passed++;
      err_clr = 1'b1; cmd_valid = 1'b1; cmd_col = 6'd63; cmd_frame = 5'd0;
      tick();
      err_clr = 1'b0; cmd_valid = 1'b0;
      total++; if (err !== 1'b1) $display("FAIL illegal_set_wins got=%b want=1", err); else passed++;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      total++; if (err !== 1'b0) $display("FAIL illegal_clr2 got=%b want=0", err); else passed++;
   endtask

   task automatic test_back_to_back();
      int            acc[$];
      logic [FB-1:0] held;
      logic          rdy_before;
      held = '0;
      cmd_valid = 1'b1;
      for (int n = 0; n < 40 && acc.size() < 3; n++) begin
         cmd_col   = CW'($urandom_range(0, NC - 1));
         cmd_frame = FW'($urandom_range(0, MF - 1));
         cmd_data  = $urandom();
         rdy_before = cmd_ready;
         tick();
         if (rdy_before === 1'b1) begin
            acc.push_back(cyc);
            held = cmd_data;
         end
         total++;
         if (acc.size() > 0 && FrameData !== held) $display("FAIL b2b_data n=%0d got=%h want=%h", n, FrameData, held);
         else passed++;
      end
      cmd_valid = 1'b0;
      total++;
      if (acc.size() != 3) $display("FAIL b2b_accepts got=%0d want=3", acc.size());
      else begin
         passed++;
         total++; if (acc[1] - acc[0] != 5) $display("FAIL b2b_gap1 got=%0d want=5", acc[1] - acc[0]); else passed++;
         total++; if (acc[2] - acc[1] != 5) $display("FAIL b2b_gap2 got=%0d want=5", acc[2] - acc[1]); else passed++;
      end
      for (int k = 0; k < 5; k++) tick();
   endtask

   task automatic test_wrap();
      force dut.frame_count = 16'hFFFF;
      #1;
      release dut.frame_count;
      m_count = 16'hFFFF;
      cmd_col = 6'd10; cmd_frame = 5'd10; cmd_data = $urandom(); cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      total++; if (frame_count !== 16'h0000) $display("FAIL wrap_count got=%h want=0000", frame_count); else passed++;
      cmd_col = 6'd11; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      total++; if (frame_count !== 16'h0001) $display("FAIL wrap_next got=%h want=0001", frame_count); else passed++;
   endtask

   task automatic test_random();
      logic [NS-1:0] ev;
      for (int n = 0; n < 400; n++) begin
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_col   = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(NC, 63)) : CW'($urandom_range(0, NC - 1));
         cmd_frame = ($urandom_range(0, 9) == 0) ? FW'($urandom_range(MF, 31)) : FW'($urandom_range(0, MF - 1));
         cmd_data  = $urandom();
         err_clr   = ($urandom_range(0, 7) == 0);
         tick();
         ev = exp_strobe();
         total++; if (FrameData !== m_data) $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, FrameData, m_data); else passed++;
         total++;
         if (FrameStrobe !== ev)
            $display("FAIL rand_strobe cyc=%0d ones=%0d want_ones=%0d idx=%0d bit=%b", cyc, $countones(FrameStrobe), $countones(ev), m_idx, FrameStrobe[m_idx]);
         else passed++;
         total++; if (cmd_ready !== (cyc >= busy_until)) $display("FAIL rand_ready cyc=%0d got=%b", cyc, cmd_ready); else passed++;
         total++; if (busy !== (cyc < busy_until)) $display("FAIL rand_busy cyc=%0d got=%b", cyc, busy); else passed++;
         total++; if (err !== m_err) $display("FAIL rand_err cyc=%0d got=%b want=%b", cyc, err, m_err); else passed++;
         total++; if (frame_count !== m_count) $display("FAIL rand_count cyc=%0d got=%h want=%h", cyc, frame_count, m_count); else passed++;
      end
      cmd_valid = 1'b0;
      err_clr   = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_single();
      test_corner();
      test_illegal();
      test_back_to_back();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
